bp_update_sequencer: RTL and testbench
======================================

Name: bp_update_sequencer

Overview:
- Sits between the branch-resolution path in execute and the frontend predictor tables (BHT, BTB).
- Buffers resolved-branch records in a small FIFO and drains them to per-table update ports, one record per cycle, under a valid/ready handshake.
- Sequences a full predictor-table invalidation sweep on fence.i or a debug flush, so the tables never see resolution writes and clear writes in the same cycle.

Parameters:
- VLEN, 39, virtual address width of PCs and targets.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- NR_ENTRIES, 64, number of predictor-table indices swept on clear (power of two).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- res_valid_i  in  1  resolved-branch record valid (single-cycle pulse).
- res_pc_i  in  VLEN  PC of the resolved instruction.
- res_target_i  in  VLEN  resolved target address.
- res_taken_i  in  1  branch taken.
- res_mispredict_i  in  1  resolution was a mispredict.
- res_cf_i  in  3  cf_type: 0 NoCF, 1 Branch, 2 Jump, 3 JumpR, 4 Return.
- clear_i  in  1  request a table-clear sweep (fence.i or debug entry).
- bht_valid_o  out  1  BHT update request.
- bht_pc_o  out  VLEN  BHT update PC.
- bht_taken_o  out  1  BHT update outcome.
- bht_ready_i  in  1  BHT accepts the update.
- btb_valid_o  out  1  BTB update request.
- btb_pc_o  out  VLEN  BTB update PC.
- btb_target_o  out  VLEN  BTB update target.
- btb_ready_i  in  1  BTB accepts the update.
- clr_o  out  1  the current bht/btb request is a clear write.
- clr_idx_o  out  $clog2(NR_ENTRIES)  index to clear.
- busy_o  out  1  FIFO non-empty or sweep in progress.
- drop_o  out  1  one-cycle pulse: a record was discarded because the FIFO was full.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE.
- Enqueue filter:
  - Records with cf==Branch are always enqueued as BHT-type.
  - Records with cf==JumpR and mispredict=1 are enqueued as BTB-type.
  - All other records are ignored: no enqueue, no drop.
- Full FIFO with a filtered-in record: the new record is discarded and drop_o=1 that cycle. Enqueue with simultaneous dequeue while full is accepted, with no drop.
- Drain (state IDLE):
  - The head record drives exactly one port: BHT-type on bht_*, BTB-type on btb_*; the other port's valid is 0.
  - Outputs are registered from the head, so the first request appears the cycle after enqueue (latency 1).
  - Dequeue on valid&&ready.
  - Outputs hold stable while valid&&!ready.
- State CLEAR:
  - Entered from IDLE on clear_i; the FIFO is flushed in the same cycle.
  - A record arriving on the clear_i cycle is dropped silently (drop_o=0).
  - bht_valid_o=btb_valid_o=clr_o=1 and clr_idx_o=counter.
  - The counter advances only when bht_ready_i && btb_ready_i are both 1 in the same cycle.
  - At counter NR_ENTRIES-1 with both ready: the counter wraps to 0 and the state returns to IDLE.
  - res_valid_i during CLEAR is ignored (no enqueue, no drop).
  - clear_i during CLEAR restarts the counter at 0.
- Pointer arithmetic: modulo DEPTH; full/empty are distinguished by an extra wrap bit.
- busy_o = !empty || state==CLEAR.
- Asynchronous reset mid-sweep or mid-drain returns immediately to the reset values.

Optional Feature:
- Macro: BP_UPDATE_SEQ_PERF_EN.
- When defined, adds output perf_drop_cnt_o[15:0] (saturating count of drop_o pulses) and perf_clr_cnt_o[15:0] (saturating count of completed sweeps). Both are cleared on reset.
- When undefined, these ports and their counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package (ariane_pkg) holds:
  - the cf_t enum;
  - the bp_upd_kind_e enum {UPD_BHT, UPD_BTB};
  - the struct bp_upd_entry_t {kind, pc, target, taken}.
- One sub-module: bp_upd_fifo, a generic DEPTH-entry FIFO of bp_upd_entry_t with full/empty, push/pop and a flush input.
- The sequencer holds the filter, the IDLE/CLEAR FSM and the sweep counter.

Test Plan:
- Branch pc=0x1000, taken=1, both ready=1 -> next cycle bht_valid_o=1, bht_pc_o=0x1000, bht_taken_o=1, btb_valid_o=0; busy_o drops 1 cycle later.
- JumpR pc=0x2000, target=0x3000, mispredict=1 -> btb_valid_o=1 with target 0x3000. Same record with mispredict=0, or cf=Return -> no request, drop_o=0.
- bht_ready_i=0, five Branch records -> fifth gives drop_o=1. Raise ready -> four BHT updates emerge in arrival order with outputs stable while stalled.
- clear_i with 2 queued records, NR_ENTRIES=64, both ready=1 -> clr_o=1 for exactly 64 cycles with clr_idx_o 0..63, queued records never emitted, then IDLE.
- During the sweep, btb_ready_i=0 for 3 cycles at index 10 -> clr_idx_o holds at 10, sweep completes in 67 cycles.
- rst_ni low at index 20 of a sweep -> all outputs 0 immediately; after release, a Branch record is serviced normally.

Source files
------------

// File: rtl/ariane_pkg.sv
// ariane_pkg: shared branch-predictor update types for the update sequencer
package ariane_pkg;
  localparam int unsigned BP_VLEN = 39;
  typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;
  typedef enum logic {UPD_BHT, UPD_BTB} bp_upd_kind_e;
  typedef struct packed {
    bp_upd_kind_e       kind;
    logic [BP_VLEN-1:0] pc;
    logic [BP_VLEN-1:0] target;
    logic               taken;
  } bp_upd_entry_t;
endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: DEPTH-entry FIFO of predictor update records with flush
module bp_upd_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  bp_upd_entry_t data_i,
  output bp_upd_entry_t data_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  bp_upd_entry_t mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // storage and wrap-bit pointers; flush discards everything queued
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/bp_update_sequencer.sv
// bp_update_sequencer: queue resolved branches and drain them to BHT/BTB, or sweep-clear both tables; optional perf counters under BP_UPDATE_SEQ_PERF_EN
module bp_update_sequencer
  import ariane_pkg::*;
#(
  parameter int unsigned VLEN       = BP_VLEN,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned NR_ENTRIES = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          res_valid_i,
  input  logic [VLEN-1:0]               res_pc_i,
  input  logic [VLEN-1:0]               res_target_i,
  input  logic                          res_taken_i,
  input  logic                          res_mispredict_i,
  input  logic [2:0]                    res_cf_i,
  input  logic                          clear_i,
  output logic                          bht_valid_o,
  output logic [VLEN-1:0]               bht_pc_o,
  output logic                          bht_taken_o,
  input  logic                          bht_ready_i,
  output logic                          btb_valid_o,
  output logic [VLEN-1:0]               btb_pc_o,
  output logic [VLEN-1:0]               btb_target_o,
  input  logic                          btb_ready_i,
  output logic                          clr_o,
  output logic [$clog2(NR_ENTRIES)-1:0] clr_idx_o,
  output logic                          busy_o,
  output logic                          drop_o
`ifdef BP_UPDATE_SEQ_PERF_EN
  ,
  output logic [15:0]                   perf_drop_cnt_o,
  output logic [15:0]                   perf_clr_cnt_o
`endif
);
  localparam int unsigned CW = $clog2(NR_ENTRIES);
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  bp_upd_entry_t in_entry, head;
  logic full, empty, push, pop, want, accept, sweeping, head_bht_v, head_btb_v;
  assign sweeping   = state_q == CLEAR;
  assign want       = res_valid_i && (cf_t'(res_cf_i) == Branch || (cf_t'(res_cf_i) == JumpR && res_mispredict_i));
  assign accept     = want && !sweeping && !clear_i;
  assign head_bht_v = !sweeping && !empty && head.kind == UPD_BHT;
  assign head_btb_v = !sweeping && !empty && head.kind == UPD_BTB;
  assign pop        = (head_bht_v && bht_ready_i) || (head_btb_v && btb_ready_i);
  assign push       = accept && (!full || pop);
  assign drop_o     = accept && full && !pop;
  assign in_entry   = '{kind: cf_t'(res_cf_i) == JumpR ? UPD_BTB : UPD_BHT, pc: res_pc_i,
                        target: res_target_i, taken: res_taken_i};
  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i && !sweeping),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_entry),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  assign clr_o        = sweeping;
  assign clr_idx_o    = cnt_q;
  assign bht_valid_o  = sweeping || head_bht_v;
  assign btb_valid_o  = sweeping || head_btb_v;
  assign bht_pc_o     = head_bht_v ? head.pc : '0;
  assign bht_taken_o  = head_bht_v && head.taken;
  assign btb_pc_o     = head_btb_v ? head.pc : '0;
  assign btb_target_o = head_btb_v ? head.target : '0;
  assign busy_o       = !empty || sweeping;
  // sweep state and index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // a clear request (re)starts the sweep; the index only moves when both tables accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else if (sweeping && bht_ready_i && btb_ready_i) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CW'(NR_ENTRIES - 1) ? IDLE : CLEAR;
    end
  end
`ifdef BP_UPDATE_SEQ_PERF_EN
  logic sweep_done;
  assign sweep_done = sweeping && !clear_i && bht_ready_i && btb_ready_i && cnt_q == CW'(NR_ENTRIES - 1);
  // saturating drop and completed-sweep counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_drop_cnt_o <= '0;
      perf_clr_cnt_o  <= '0;
    end else begin
      if (drop_o && perf_drop_cnt_o != 16'hFFFF) perf_drop_cnt_o <= perf_drop_cnt_o + 1'b1;
      if (sweep_done && perf_clr_cnt_o != 16'hFFFF) perf_clr_cnt_o <= perf_clr_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_bp_update_sequencer.sv
// tb_bp_update_sequencer: directed and random stimulus against a queue-based reference model
module tb_bp_update_sequencer;
  logic clk = 0, rst_ni = 0;
  logic res_valid_i = 0, res_taken_i = 0, res_mispredict_i = 0, clear_i = 0;
  logic [38:0] res_pc_i = '0, res_target_i = '0;
  logic [2:0] res_cf_i = '0;
  logic bht_ready_i = 0, btb_ready_i = 0;
  logic bht_valid_o, bht_taken_o, btb_valid_o, clr_o, busy_o, drop_o;
  logic [38:0] bht_pc_o, btb_pc_o, btb_target_o;
  logic [5:0] clr_idx_o;
  always #5 clk = ~clk;
  bp_update_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni), .res_valid_i(res_valid_i), .res_pc_i(res_pc_i),
    .res_target_i(res_target_i), .res_taken_i(res_taken_i), .res_mispredict_i(res_mispredict_i),
    .res_cf_i(res_cf_i), .clear_i(clear_i), .bht_valid_o(bht_valid_o), .bht_pc_o(bht_pc_o),
    .bht_taken_o(bht_taken_o), .bht_ready_i(bht_ready_i), .btb_valid_o(btb_valid_o),
    .btb_pc_o(btb_pc_o), .btb_target_o(btb_target_o), .btb_ready_i(btb_ready_i), .clr_o(clr_o),
    .clr_idx_o(clr_idx_o), .busy_o(busy_o), .drop_o(drop_o)
  );
  typedef struct {bit btb; logic [38:0] pc; logic [38:0] tg; logic tk;} rec_t;
  rec_t q[$];
  bit m_sweep = 0;
  int m_idx = 0;
  int n_vec = 0, n_err = 0, clr_cycles = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {bht_valid_o, bht_taken_o, btb_valid_o, clr_o, busy_o, drop_o, clr_idx_o}, '0);
    check({tag, "_pc"}, {bht_pc_o, btb_pc_o, btb_target_o}, '0);
  endtask
  // apply one cycle of inputs (called at posedge+1), check at negedge, advance model at posedge
  task automatic step(input logic v, input logic [2:0] cf, input logic mp, input logic tk,
                      input logic [38:0] pc, input logic [38:0] tg, input logic clr,
                      input logic br, input logic xr);
    bit want, popped, full, drop;
    rec_t h;
    logic [11:0] ctl;
    logic [38:0] e_bpc, e_xpc, e_xtg;
    res_valid_i = v; res_cf_i = cf; res_mispredict_i = mp; res_taken_i = tk;
    res_pc_i = pc; res_target_i = tg; clear_i = clr; bht_ready_i = br; btb_ready_i = xr;
    @(negedge clk);
    want = v && (cf == 3'd1 || (cf == 3'd3 && mp));
    popped = 0; e_bpc = '0; e_xpc = '0; e_xtg = '0;
    full = q.size() == 4;
    if (m_sweep) ctl = {4'b1011, 1'b1, 1'b0, 6'(m_idx)};
    else if (q.size() > 0) begin
      h = q[0];
      popped = h.btb ? xr : br;
      drop = want && !clr && full && !popped;
      if (h.btb) begin e_xpc = h.pc; e_xtg = h.tg; end
      else e_bpc = h.pc;
      ctl = {!h.btb, !h.btb && h.tk, h.btb, 1'b0, 1'b1, drop, 6'd0};
    end else ctl = '0;
    if (clr_o) clr_cycles++;
    check("ctl", {bht_valid_o, bht_taken_o, btb_valid_o, clr_o, busy_o, drop_o, clr_idx_o}, ctl);
    check("bht_pc", bht_pc_o, e_bpc);
    check("btb_pc_tgt", {btb_pc_o, btb_target_o}, {e_xpc, e_xtg});
    @(posedge clk);
    if (clr) begin
      q.delete(); m_sweep = 1; m_idx = 0;
    end else if (m_sweep) begin
      if (br && xr) begin
        if (m_idx == 63) begin m_sweep = 0; m_idx = 0; end
        else m_idx++;
      end
    end else begin
      if (popped) void'(q.pop_front());
      if (want && (!full || popped)) q.push_back('{cf == 3'd3, pc, tg, tk});
    end
    #1;
  endtask
  task automatic idle(input int n, input logic br, input logic xr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 0, br, xr);
  endtask
  initial begin
    int stall;
    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_ni = 1;
    // single branch, then jumps
    step(1, 3'd1, 0, 1, 39'h1000, '0, 0, 1, 1);
    idle(3, 1, 1);
    step(1, 3'd3, 1, 0, 39'h2000, 39'h3000, 0, 1, 1);
    idle(2, 1, 1);
    step(1, 3'd3, 0, 0, 39'h2000, 39'h3000, 0, 1, 1);
    step(1, 3'd4, 1, 1, 39'h2000, 39'h3000, 0, 1, 1);
    idle(2, 1, 1);
    // stalled BHT: fifth record drops, then ordered drain
    for (int i = 0; i < 5; i++) step(1, 3'd1, 0, 39'(i & 1), 39'h4000 + 39'(i * 4), '0, 0, 0, 1);
    idle(2, 0, 1);
    idle(6, 1, 1);
    // clear with queued records
    step(1, 3'd1, 0, 1, 39'h5000, '0, 0, 0, 0);
    step(1, 3'd1, 0, 0, 39'h5004, '0, 0, 0, 0);
    clr_cycles = 0;
    step(1, 3'd1, 0, 1, 39'h5008, '0, 1, 0, 0);
    idle(70, 1, 1);
    check("sweep_len", 128'(clr_cycles), 128'd64);
    // sweep with BTB stall at index 10
    clr_cycles = 0; stall = 0;
    step(0, 0, 0, 0, '0, '0, 1, 1, 1);
    for (int i = 0; i < 75; i++) begin
      if (m_sweep && m_idx == 10 && stall < 3) begin stall++; step(1, 3'd1, 0, 1, 39'h77, '0, 0, 1, 0); end
      else step(0, 0, 0, 0, '0, '0, 0, 1, 1);
    end
    check("stall_sweep_len", 128'(clr_cycles), 128'd67);
    // async reset mid-sweep
    step(0, 0, 0, 0, '0, '0, 1, 1, 1);
    idle(20, 1, 1);
    res_valid_i = 0; clear_i = 0;
    rst_ni = 0;
    #1;
    check_zero("async_rst");
    q.delete(); m_sweep = 0; m_idx = 0;
    @(posedge clk);
    #1 rst_ni = 1;
    step(1, 3'd1, 0, 1, 39'h6000, '0, 0, 1, 1);
    idle(2, 1, 1);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom % 2 == 0, 3'($urandom), 1'($urandom), 1'($urandom), 39'({$urandom, $urandom}),
           39'({$urandom, $urandom}), $urandom % 80 == 0, $urandom % 4 != 0, $urandom % 4 != 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
